erode: RTL and testbench
========================

Name: erode

Overview:
- Binary 3x3 erosion stage sitting directly upstream of the dilate stage; together they form the morphological opening applied to the thresholded edge map.
- Consumes the 1-bit thresholded pixel stream driven by the 800x600 VGA timing counters and works on the half-resolution 400x300 grid, where each pixel is doubled in both axes.
- Produces erode_value, which feeds dilate directly.

Parameters:
- Hor_Addr_Time, 800, active horizontal pixels of the display timing.
- Width, Hor_Addr_Time>>1, columns in the half-resolution grid (400).
- Ver_Addr_Time, 600, active vertical lines.
- Height, Ver_Addr_Time>>1, rows in the half-resolution grid (300).

Ports:
- clk  input  1  pixel clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- hcount  input  11  horizontal timing counter, including blanking.
- vcount  input  11  vertical timing counter, including blanking.
- bin_value  input  1  thresholded pixel at (hcount, vcount).
- erode_value  output  1  eroded pixel, registered.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: while rst=1, erode_value=0, both pipeline stage registers=0, and all three line buffers are cleared to 0. No buffer writes or row rotations occur during reset.
- Grid coordinates: x = hcount>>1, y = vcount>>1.
- Storage: three line buffers lb0, lb1, lb2, each Width x 1 bit. lb0 holds grid row y-2, lb1 holds row y-1, lb2 holds row y.
- Write: on a clock edge with vcount[0]=0, hcount[0]=0 and x<Width, lb2[x] <= bin_value. Indices x>=Width are never written.
- Rotate: on a clock edge with vcount[0]=0 and hcount=0, lb0 <= lb1 and lb1 <= lb2, whole-row parallel.
- Write and rotate on the same edge (hcount=0): lb1[0] receives the OLD lb2[0]; lb2[0] receives the new bin_value.
- Window reads: taps are pixel[r][c] = lb_r[x-c] for r,c in {0,1,2}. Taps read register contents from before the edge, so the tap lb2[x] returns the previous frame's/line's value on the write cycle.
- Tap validity: a tap is valid iff 0 <= x-c <= Width-1 and 0 <= y-2+r <= Height-1. Invalid taps read as 1, the erosion-neutral value, so image borders are not eroded.
- Centre validity: the window centre is (x-1, y-1). centre_valid = (1 <= x <= Width) and (1 <= y <= Height).
- Pipeline stage 1 (registered): row_and[r] = AND of the three taps of row r; centre_valid is also registered.
- Pipeline stage 2 (registered): erode_value = row_and[0] & row_and[1] & row_and[2] & centre_valid_d1.
- Latency: exactly 2 clk cycles from the hcount/vcount presentation to erode_value. It is a fixed pipeline with no stalls.
- Blanking: any counter value with the centre outside the grid forces erode_value=0 after the same 2-cycle latency.
- Reset mid-frame: the pipeline and buffers clear asynchronously. Output stays 0 until valid rows are refilled. Output is correct from the second full grid row written after rst deasserts.
- Width rules: subtractions x-c are evaluated in 12 bits, so negative results fail the range check rather than wrapping.

Test Plan:
1. All-ones frame (bin_value=1 throughout) → erode_value=1 for every centre with 1<=x<=400 and 1<=y<=300, including border centres x=1 and y=1 (neutral padding); 0 in blanking (x>400 or y>300). Checked 2 cycles after the counters.
2. Single 0 pixel at grid (200,150) in an all-ones frame → erode_value=0 exactly for centres x-1 in 199..201 and y-1 in 149..151 (a 3x3 hole); 1 elsewhere in the active area.
3. Single 1 pixel at grid (50,50) in an all-zeros frame → erode_value=0 everywhere. A 3x3 block of ones centred at (50,50) → erode_value=1 only for centre (50,50), asserted while x=51, y=51.
4. Latency check: at hcount=102, vcount=102 (centre (50,50) in case 3) → erode_value changes on the 2nd rising edge after the counters are applied, and is held 2 clocks per grid pixel.
5. Same-edge write/rotate: bin_value=1 at grid column 0 on row y, and 0 on row y+1 → after the rotation at row y+1, lb1[0]=1 and lb2[0]=0. Verify via erode_value=0 for centre (0,y) once row y+1 is written.
6. Assert rst for 3 clocks mid-line at hcount=400, vcount=300 → erode_value=0 asynchronously within the same cycle; after release, output is 0 until two grid rows are refilled, then matches the reference model.

Source files
------------

// File: rtl/erode.sv
// Binary 3x3 erosion over the half-resolution grid carried by the VGA counters.
// It reads three one-row line buffers and has a two-stage registered output pipeline.
module erode #(
  parameter int unsigned Hor_Addr_Time = 800,
  parameter int unsigned Width         = Hor_Addr_Time >> 1,
  parameter int unsigned Ver_Addr_Time = 600,
  parameter int unsigned Height        = Ver_Addr_Time >> 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        bin_value,
  output logic        erode_value
);

  localparam int unsigned IDX_W = $clog2(Width);
  localparam logic [11:0] W12   = 12'(Width);
  localparam logic [11:0] H12   = 12'(Height);

  logic [11:0]      x12;
  logic [11:0]      y12;
  logic             wr_en_c;
  logic             rot_c;
  logic             centre_valid_c;
  logic [2:0]       row_and_c;
  logic [Width-1:0] lb [3];
  logic [2:0]       row_and_q;
  logic             centre_valid_q;

  // Coordinates are 12 bits wide so that x-c and y-2+r go negative instead of wrapping.
  assign x12 = {2'b00, hcount[10:1]};
  assign y12 = {2'b00, vcount[10:1]};

  assign wr_en_c = ~vcount[0] & ~hcount[0] & (x12 < W12);
  assign rot_c   = ~vcount[0] & (hcount == 11'd0);

  assign centre_valid_c = (x12 >= 12'd1) && (x12 <= W12) &&
                          (y12 >= 12'd1) && (y12 <= H12);

  // lb[0] holds row y-2, lb[1] row y-1, lb[2] row y. Non-blocking assignments make the
  // rotation take the old lb[2] while the same edge writes the new pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb[0] <= '0;
      lb[1] <= '0;
      lb[2] <= '0;
    end else begin
      if (rot_c) begin
        lb[0] <= lb[1];
        lb[1] <= lb[2];
      end
      if (wr_en_c) begin
        lb[2][x12[IDX_W-1:0]] <= bin_value;
      end
    end
  end

  // A tap outside the grid reads as 1, so erosion leaves the image borders intact.
  for (genvar r = 0; r < 3; r++) begin : g_row
    logic [11:0] ty;
    logic [2:0]  tap_c;
    logic        row_ok;
    assign ty     = y12 - 12'(2 - r);
    assign row_ok = ~ty[11] && (ty < H12);
    for (genvar c = 0; c < 3; c++) begin : g_col
      logic [11:0] tx;
      assign tx       = x12 - 12'(c);
      assign tap_c[c] = (row_ok && ~tx[11] && (tx < W12)) ? lb[r][tx[IDX_W-1:0]] : 1'b1;
    end
    assign row_and_c[r] = &tap_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_and_q      <= '0;
      centre_valid_q <= 1'b0;
      erode_value    <= 1'b0;
    end else begin
      row_and_q      <= row_and_c;
      centre_valid_q <= centre_valid_c;
      erode_value    <= (&row_and_q) & centre_valid_q;
    end
  end

endmodule

// File: tb/tb_erode.sv
// Directed bench for erode. It drives the counters line by line over selected grid rows and
// compares each output with an erosion model of the test image, applied two clocks later.
module tb_erode;

  localparam int W = 400;
  localparam int H = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        bin_value;
  logic        erode_value;

  int checks   = 0;
  int failures = 0;
  int pat      = 0;

  erode dut (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .bin_value   (bin_value),
    .erode_value (erode_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Test images on the 400x300 grid
  function automatic bit img(input int gx, input int gy);
    case (pat)
      0:       return 1'b1;
      1:       return !(gx == 200 && gy == 150);
      2:       return (gx == 50 && gy == 50);
      3:       return (gx >= 49 && gx <= 51 && gy >= 49 && gy <= 51);
      4:       return !(gx == 0 && gy == 11);
      5:       return !(gx == 0 && gy == 10);
      6:       return (gy >= 150);
      default: return 1'b0;
    endcase
  endfunction

  // Expected output for the counters (h, v). On a write cycle the newest tap still holds
  // the previous row's pixel in that column.
  function automatic bit model(input int h, input int v);
    int x = h >> 1;
    int y = v >> 1;
    bit stale = ((v % 2) == 0) && ((h % 2) == 0);
    bit acc = 1'b1;
    if (!(x >= 1 && x <= W && y >= 1 && y <= H)) return 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int gx = x - c;
        int gy = y - 2 + r;
        if (gx >= 0 && gx < W && gy >= 0 && gy < H)
          acc = acc & ((stale && r == 2 && c == 0) ? img(gx, gy - 1) : img(gx, gy));
      end
    end
    return acc;
  endfunction

  // One display line, including two blanking columns past the active area.
  task automatic drive_line(input int v, input bit chk);
    bit exp_prev = 1'b0;
    bit have_prev = 1'b0;
    int h_prev = 0;
    for (int h = 0; h < 804; h++) begin
      hcount    = 11'(h);
      vcount    = 11'(v);
      bin_value = img(h >> 1, v >> 1);
      @(posedge clk); #1;
      if (chk && have_prev)
        check($sformatf("px p%0d h=%0d v=%0d", pat, h_prev, v), erode_value, exp_prev);
      exp_prev  = model(h, v);
      h_prev    = h;
      have_prev = 1'b1;
    end
  endtask

  task automatic run_rows(input int y0, input int y1, input int chk0);
    for (int y = y0; y <= y1; y++) begin
      drive_line(2 * y, (y >= chk0) && (y > y0));
      drive_line(2 * y + 1, y >= chk0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    hcount    = '0;
    vcount    = '0;
    bin_value = 1'b0;
    #1;
    check("reset_out_async", erode_value, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_held", erode_value, 1'b0);
    rst = 1'b0;

    // All ones: top, left and bottom borders stay 1; blanking is 0
    pat = 0;
    run_rows(0, 2, 0);
    run_rows(298, 301, 300);

    // Single hole at (200,150)
    pat = 1;
    run_rows(148, 153, 150);

    // A lone 1 at (50,50) is eroded away; a 3x3 block leaves only its centre
    pat = 2;
    run_rows(48, 52, 50);
    pat = 3;
    run_rows(48, 53, 50);

    // Column 0 across the rotation edge, in both orders
    pat = 4;
    run_rows(9, 12, 11);
    pat = 5;
    run_rows(8, 12, 10);

    // Reset asserted mid-line at hcount=400, vcount=300 on an all-ones image
    pat = 0;
    run_rows(147, 149, 1000);
    for (int h = 0; h <= 400; h++) begin
      hcount    = 11'(h);
      vcount    = 11'd300;
      bin_value = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_rst", erode_value, model(399, 300));
    #2 rst = 1'b1;
    #1;
    check("rst_async", erode_value, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_hold%0d", i), erode_value, 1'b0);
    end
    rst = 1'b0;
    // The cleared rows 148 and 149 act as zeros until fresh rows replace them
    pat = 6;
    run_rows(150, 153, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
